// File: rtl/eep_dram_arb.sv
// Arbitrates the single EEP data-DRAM port among NUM_REQ requesters with a two-stage pipeline.
// Define EEP_DRAM_ARB_FIXED_PRIO_EN to select fixed lowest-index-first priority instead of round-robin.
module eep_dram_arb #(
  parameter int NUM_REQ   = 2,
  parameter int REG_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*REG_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [REG_WIDTH-1:0]           rsp_rdata,
  output logic                           dram_we,
  output logic [REG_WIDTH-1:0]           dram_rd_ad,
  output logic [REG_WIDTH-1:0]           dram_wt_ad,
  output logic [REG_WIDTH-1:0]           dram_in,
  input  logic [REG_WIDTH-1:0]           dram_out
);

  localparam int RR_IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   w_ready;
  logic                 w_found;
  logic                 w_accept;
  logic [RR_IDX_W-1:0]  w_gnt_idx;
  int unsigned          w_scan;
  logic                 w_sel_we;
  logic [REG_WIDTH-1:0] w_sel_addr;
  logic [REG_WIDTH-1:0] w_sel_wdata;

  logic                 r_dram_we;
  logic [REG_WIDTH-1:0] r_dram_rd_ad;
  logic [REG_WIDTH-1:0] r_dram_wt_ad;
  logic [REG_WIDTH-1:0] r_dram_in;
  logic                 r_s1_rd;
  logic [RR_IDX_W-1:0]  r_s1_tag;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [REG_WIDTH-1:0] r_last_rdata;

`ifndef EEP_DRAM_ARB_FIXED_PRIO_EN
  logic [RR_IDX_W-1:0]  r_rr_ptr;
`endif

  // First valid requester found scanning upward from the pointer (from 0 in fixed mode).
  always_comb begin
    w_ready   = '0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_scan    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef EEP_DRAM_ARB_FIXED_PRIO_EN
      w_scan = k;
`else
      w_scan = (32'(r_rr_ptr) + k) % NUM_REQ;
`endif
      if (!w_found && req_valid[w_scan]) begin
        w_found   = 1'b1;
        w_gnt_idx = RR_IDX_W'(w_scan);
      end
    end
    if (w_found && !rst) begin
      w_ready[w_gnt_idx] = 1'b1;
    end
  end

  assign w_accept    = w_found && !rst;
  assign w_sel_we    = req_we[w_gnt_idx];
  assign w_sel_addr  = req_addr[w_gnt_idx*REG_WIDTH +: REG_WIDTH];
  assign w_sel_wdata = req_wdata[w_gnt_idx*REG_WIDTH +: REG_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dram_we    <= 1'b0;
      r_dram_rd_ad <= '0;
      r_dram_wt_ad <= '0;
      r_dram_in    <= '0;
      r_s1_rd      <= 1'b0;
      r_s1_tag     <= '0;
      r_rsp_valid  <= '0;
      r_last_rdata <= '0;
    end else begin
      r_dram_we <= w_accept && w_sel_we;
      if (w_accept && w_sel_we) begin
        r_dram_wt_ad <= w_sel_addr;
        r_dram_in    <= w_sel_wdata;
      end
      if (w_accept && !w_sel_we) begin
        r_dram_rd_ad <= w_sel_addr;
      end
      r_s1_rd     <= w_accept && !w_sel_we;
      r_s1_tag    <= w_gnt_idx;
      r_rsp_valid <= '0;
      if (r_s1_rd) begin
        r_rsp_valid[r_s1_tag] <= 1'b1;
      end
      if (|r_rsp_valid) begin
        r_last_rdata <= dram_out;
      end
    end
  end

`ifndef EEP_DRAM_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_gnt_idx == RR_IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end
`endif

  // Read data comes straight from the DRAM on the response cycle, then is held.
  assign rsp_rdata  = (|r_rsp_valid) ? dram_out : r_last_rdata;
  assign req_ready  = w_ready;
  assign rsp_valid  = r_rsp_valid;
  assign dram_we    = r_dram_we;
  assign dram_rd_ad = r_dram_rd_ad;
  assign dram_wt_ad = r_dram_wt_ad;
  assign dram_in    = r_dram_in;

endmodule

// File: tb/tb_eep_dram_arb.sv
// Self-checking bench for eep_dram_arb: directed scenarios plus randomized traffic vs a timeline model.
module tb_eep_dram_arb;
  localparam int NUM_REQ = 2;
  localparam int RW      = 16;
  localparam int NCYC    = 400;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid, req_ready, req_we, rsp_valid;
  logic [2*RW-1:0]   req_addr, req_wdata;
  logic [RW-1:0]     rsp_rdata, dram_rd_ad, dram_wt_ad, dram_in;
  logic [RW-1:0]     dram_out = '0;
  logic              dram_we;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  eep_dram_arb #(.NUM_REQ(NUM_REQ), .REG_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .dram_we(dram_we), .dram_rd_ad(dram_rd_ad), .dram_wt_ad(dram_wt_ad), .dram_in(dram_in),
    .dram_out(dram_out)
  );

  // Synchronous DRAM environment; unwritten locations read a fixed address-derived pattern.
  logic [RW-1:0] dram_mem [65536];
  bit            dram_wr  [65536];

  function automatic logic [RW-1:0] init_val(input logic [RW-1:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (dram_we) begin
      dram_mem[dram_wt_ad] <= dram_in;
      dram_wr[dram_wt_ad]  <= 1'b1;
    end
    dram_out <= dram_wr[dram_rd_ad] ? dram_mem[dram_rd_ad] : init_val(dram_rd_ad);
  end

  task automatic drive(input logic r, input logic [1:0] v, input logic [1:0] we,
                       input logic [RW-1:0] a0, input logic [RW-1:0] a1,
                       input logic [RW-1:0] d0, input logic [RW-1:0] d1);
    rst       = r;
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive(1'b1, 2'b11, 2'b00, 16'h0001, 16'h0002, '0, '0);
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready_c0 got %b exp 00", req_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready_c1 got %b exp 00", req_ready); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 16'h0) begin n_err++; $display("FAIL reset_rsp_rdata got %h exp 0000", rsp_rdata); end
    n_cmp++; if (dram_we !== 1'b0) begin n_err++; $display("FAIL reset_dram_we got %b exp 0", dram_we); end
    n_cmp++; if ({dram_rd_ad, dram_wt_ad, dram_in} !== 48'h0) begin
      n_err++; $display("FAIL reset_dram_bus got %h/%h/%h exp 0/0/0", dram_rd_ad, dram_wt_ad, dram_in);
    end
    @(negedge clk);
    drive(1'b0, 2'b11, 2'b00, 16'h0001, 16'h0002, '0, '0);
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL reset_first_grant got %b exp 01", req_ready); end
    idle(3);
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive(1'b0, 2'b01, 2'b01, 16'h0010, '0, 16'hBEEF, '0);
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL wr_ready got %b exp 01", req_ready); end
    @(negedge clk);
    drive(1'b0, 2'b01, 2'b00, 16'h0010, '0, '0, '0);
    #1;
    n_cmp++; if (dram_we !== 1'b1) begin n_err++; $display("FAIL wr_dram_we got %b exp 1", dram_we); end
    n_cmp++; if (dram_wt_ad !== 16'h0010) begin n_err++; $display("FAIL wr_wt_ad got %h exp 0010", dram_wt_ad); end
    n_cmp++; if (dram_in !== 16'hBEEF) begin n_err++; $display("FAIL wr_dram_in got %h exp beef", dram_in); end
    @(negedge clk);
    drive(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
    #1;
    n_cmp++; if (dram_we !== 1'b0) begin n_err++; $display("FAIL wr_we_one_cycle got %b exp 0", dram_we); end
    n_cmp++; if (dram_rd_ad !== 16'h0010) begin n_err++; $display("FAIL rd_rd_ad got %h exp 0010", dram_rd_ad); end
    n_cmp++; if (dram_wt_ad !== 16'h0010) begin n_err++; $display("FAIL wr_wt_ad_hold got %h exp 0010", dram_wt_ad); end
    @(negedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL rd_rsp_valid got %b exp 01", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 16'hBEEF) begin n_err++; $display("FAIL rd_rsp_rdata got %h exp beef", rsp_rdata); end
    @(negedge clk);
    #1;
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL rd_rsp_one_cycle got %b exp 00", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 16'hBEEF) begin n_err++; $display("FAIL rd_rdata_hold got %h exp beef", rsp_rdata); end
    idle(2);
  endtask

  task automatic test_round_robin();
    int g_hist [10];
    int g_exp;
    @(negedge clk);
    drive(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 8) drive(1'b0, 2'b11, 2'b00, 16'h0001, 16'h0002, '0, '0);
      else       drive(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
      #1;
`ifdef EEP_DRAM_ARB_FIXED_PRIO_EN
      g_exp = 0;
`else
      g_exp = k % 2;
`endif
      g_hist[k] = g_exp;
      if (k < 8) begin
        n_cmp++; if (req_ready !== 2'(1 << g_exp)) begin
          n_err++; $display("FAIL rr_grant k=%0d got %b exp %b", k, req_ready, 2'(1 << g_exp));
        end
      end
      if (k >= 2) begin
        n_cmp++; if (rsp_valid !== 2'(1 << g_hist[k-2])) begin
          n_err++; $display("FAIL rr_rsp_valid k=%0d got %b exp %b", k, rsp_valid, 2'(1 << g_hist[k-2]));
        end
        n_cmp++; if (rsp_rdata !== init_val(16'(g_hist[k-2] + 1))) begin
          n_err++; $display("FAIL rr_rsp_rdata k=%0d got %h exp %h", k, rsp_rdata, init_val(16'(g_hist[k-2] + 1)));
        end
      end
    end
    idle(2);
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    drive(1'b0, 2'b01, 2'b00, 16'h0003, '0, '0, '0);
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_ready got %b exp 01", req_ready); end
    @(negedge clk);
    drive(1'b1, 2'b01, 2'b00, 16'h0003, '0, '0, '0);
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL mid_ready_in_rst got %b exp 00", req_ready); end
    @(negedge clk);
    drive(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
    #1;
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL mid_rsp_dropped got %b exp 00", rsp_valid); end
    n_cmp++; if (dram_we !== 1'b0) begin n_err++; $display("FAIL mid_dram_we got %b exp 0", dram_we); end
    @(negedge clk);
    drive(1'b0, 2'b10, 2'b10, '0, 16'h0005, '0, 16'hA5A5);
    @(negedge clk);
    drive(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
    @(negedge clk);
    drive(1'b0, 2'b00, 2'b00, '0, '0, '0, '0);
    #1;
    n_cmp++; if (dram_we !== 1'b0) begin n_err++; $display("FAIL mid_wr_we_after_rst got %b exp 0", dram_we); end
    n_cmp++; if (dram_wt_ad !== 16'h0) begin n_err++; $display("FAIL mid_wt_ad_after_rst got %h exp 0000", dram_wt_ad); end
    idle(2);
  endtask

  task automatic test_raw_cross();
    @(negedge clk);
    drive(1'b0, 2'b01, 2'b01, 16'h0007, '0, 16'h1234, '0);
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL raw_wr_ready got %b exp 01", req_ready); end
    @(negedge clk);
    drive(1'b0, 2'b10, 2'b00, '0, 16'h0007, '0, '0);
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL raw_rd_ready got %b exp 10", req_ready); end
    idle(2);
    #1;
    n_cmp++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL raw_rsp_valid got %b exp 10", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 16'h1234) begin n_err++; $display("FAIL raw_rsp_rdata got %h exp 1234", rsp_rdata); end
    idle(2);
  endtask

  // Reference: per-cycle accept timeline; outputs at cycle c follow from accepts at c-1 and c-2.
  bit            a_v   [NCYC];
  bit            a_we  [NCYC];
  int            a_g   [NCYC];
  logic [RW-1:0] a_addr[NCYC];
  logic [RW-1:0] a_wd  [NCYC];
  logic [RW-1:0] a_rd  [NCYC];
  bit            h_rst [NCYC];
  logic [RW-1:0] ref_mem [int unsigned];

  task automatic test_random();
    bit            p_v [2];
    bit            p_we[2];
    logic [RW-1:0] p_a [2];
    logic [RW-1:0] p_d [2];
    int            ptr = 0;
    int            g;
    bit            r;
    logic          e_dwe;
    logic [1:0]    e_rsp, e_rdy;
    logic [RW-1:0] e_rd = '0, e_wt = '0, e_in = '0, e_rdata = '0;
    for (int i = 0; i < 2; i++) p_v[i] = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      r = (c < 2) || ($urandom_range(39) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!p_v[i] && $urandom_range(3) != 0) begin
          p_v[i]  = 1'b1;
          p_we[i] = 1'($urandom_range(1));
          p_a[i]  = 16'h0100 | 16'($urandom_range(15));
          p_d[i]  = 16'($urandom);
        end
      end
      drive(r, {p_v[1], p_v[0]}, {p_we[1], p_we[0]}, p_a[0], p_a[1], p_d[0], p_d[1]);
      #1;
      if (c >= 1) begin
        e_rsp = 2'b00;
        if (h_rst[c-1]) begin
          e_dwe = 1'b0; e_rd = '0; e_wt = '0; e_in = '0; e_rdata = '0;
        end else begin
          e_dwe = a_v[c-1] && a_we[c-1];
          if (e_dwe) begin e_wt = a_addr[c-1]; e_in = a_wd[c-1]; end
          if (a_v[c-1] && !a_we[c-1]) e_rd = a_addr[c-1];
          if (c >= 2 && a_v[c-2] && !a_we[c-2]) begin
            e_rsp[a_g[c-2]] = 1'b1;
            e_rdata = a_rd[c-2];
          end
        end
        n_cmp++; if (dram_we !== e_dwe) begin n_err++; $display("FAIL rnd_dram_we c=%0d got %b exp %b", c, dram_we, e_dwe); end
        n_cmp++; if (dram_wt_ad !== e_wt) begin n_err++; $display("FAIL rnd_wt_ad c=%0d got %h exp %h", c, dram_wt_ad, e_wt); end
        n_cmp++; if (dram_in !== e_in) begin n_err++; $display("FAIL rnd_dram_in c=%0d got %h exp %h", c, dram_in, e_in); end
        n_cmp++; if (dram_rd_ad !== e_rd) begin n_err++; $display("FAIL rnd_rd_ad c=%0d got %h exp %h", c, dram_rd_ad, e_rd); end
        n_cmp++; if (rsp_valid !== e_rsp) begin n_err++; $display("FAIL rnd_rsp_valid c=%0d got %b exp %b", c, rsp_valid, e_rsp); end
        n_cmp++; if (rsp_rdata !== e_rdata) begin n_err++; $display("FAIL rnd_rsp_rdata c=%0d got %h exp %h", c, rsp_rdata, e_rdata); end
      end
      g = -1;
      if (!r) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (g < 0 && p_v[(ptr + k) % NUM_REQ]) g = (ptr + k) % NUM_REQ;
        end
      end
      e_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
      n_cmp++; if (req_ready !== e_rdy) begin n_err++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, req_ready, e_rdy); end
      h_rst[c] = r;
      a_v[c]   = (g >= 0);
      if (g >= 0) begin
        a_g[c] = g; a_we[c] = p_we[g]; a_addr[c] = p_a[g]; a_wd[c] = p_d[g];
        a_rd[c] = ref_mem.exists(32'(p_a[g])) ? ref_mem[32'(p_a[g])] : init_val(p_a[g]);
        if (p_we[g]) ref_mem[32'(p_a[g])] = p_d[g];
        p_v[g] = 1'b0;
`ifndef EEP_DRAM_ARB_FIXED_PRIO_EN
        ptr = (g + 1) % NUM_REQ;
`endif
      end
      if (r) ptr = 0;
    end
    idle(3);
  endtask

  initial begin
    drive(1'b1, 2'b00, 2'b00, '0, '0, '0, '0);
    test_reset();
    test_write_read();
    test_round_robin();
    test_reset_midop();
    test_raw_cross();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
